// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: blank code,
// scan FSM encoding and the default digit-code width.
package display_pkg;

  localparam int DIG_W_DEF = 5;

  // Code that BCD_7segmentos decodes to all segments off.
  localparam logic [4:0] BLANK_CODE = 5'd17;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/BCD_7segmentos.sv
// Digit-code to 7-segment decoder, active-high segments {a,b,c,d,e,f,g}.
// Codes 0-9 light the decimal glyph; every other code (incl. BLANK_CODE) is dark.
module BCD_7segmentos #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_bcd,
  output logic [6:0]   o_seg
);

  // Glyph lookup.
  always_comb begin
    o_seg = 7'b0000000;
    case (i_bcd)
      W'(0):   o_seg = 7'b1111110;
      W'(1):   o_seg = 7'b0110000;
      W'(2):   o_seg = 7'b1101101;
      W'(3):   o_seg = 7'b1111001;
      W'(4):   o_seg = 7'b0110011;
      W'(5):   o_seg = 7'b1011011;
      W'(6):   o_seg = 7'b1011111;
      W'(7):   o_seg = 7'b1110000;
      W'(8):   o_seg = 7'b1111111;
      W'(9):   o_seg = 7'b1111011;
      default: o_seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// Multiplexed N-digit 7-segment scanner with guard blanking, double-buffered
// digit load and leading-zero blanking; blinking is built when DISPLAY_SCAN_BLINK_EN is defined.
module display_scan
  import display_pkg::*;
#(
  parameter int N_DIGITS      = 3,
  parameter int DIG_W         = DIG_W_DEF,
  parameter int PRESCALE      = 50000,
  parameter int GUARD         = 16,
  parameter int BLINK_FRAMES  = 64,
  parameter int EN_ACTIVE_LOW = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_DIGITS*DIG_W-1:0] digits,
  input  logic                      update,
  input  logic                      lzb,
  input  logic [N_DIGITS-1:0]       blink_mask,
  output logic [N_DIGITS-1:0]       enable,
  output logic [6:0]                segmentos,
  output logic                      frame_tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - GUARD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [DIG_W-1:0] BLANK      = DIG_W'(BLANK_CODE);
  localparam logic [DIG_W-1:0] ZERO       = DIG_W'(0);
  localparam logic [N_DIGITS-1:0] EN_OFF  = (EN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
  // With no guard interval the scan lives permanently in SHOW.
  localparam scan_state_t ST_RESET = (GUARD == 0) ? ST_SHOW : ST_GUARD;

  scan_state_t               r_state, w_state_next;
  logic [CNT_W-1:0]          r_cnt, w_cnt_next;
  logic [IDX_W-1:0]          r_idx, w_idx_next;
  logic                      w_frame_start;
  logic [N_DIGITS*DIG_W-1:0] r_pending, r_active, w_pending_next, w_active_next;
  logic [DIG_W-1:0]          r_code, w_code_next, w_sel;
  logic [N_DIGITS-1:0]       r_enable, w_en_next, w_onehot, w_lz;
  logic                      r_frame_tick;
  logic                      w_blank_sel;
  logic                      w_blink_on_next;
  logic [N_DIGITS-1:0]       w_blink_mask_eff;

  // Slot prescaler, guard/show sequencing and slot index.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt + CNT_ONE;
    w_idx_next    = r_idx;
    w_frame_start = 1'b0;
    case (r_state)
      ST_GUARD: begin
        if (r_cnt == GUARD_LAST) begin
          w_state_next = ST_SHOW;
          w_cnt_next   = '0;
        end else begin
          w_state_next = ST_GUARD;
        end
      end
      ST_SHOW: begin
        if (r_cnt == SHOW_LAST) begin
          w_state_next = (GUARD == 0) ? ST_SHOW : ST_GUARD;
          w_cnt_next   = '0;
          if (r_idx == IDX_LAST) begin
            w_idx_next    = '0;
            w_frame_start = 1'b1;
          end else begin
            w_idx_next = r_idx + IDX_ONE;
          end
        end else begin
          w_state_next = ST_SHOW;
        end
      end
      default: begin
        w_state_next = ST_RESET;
        w_cnt_next   = '0;
        w_idx_next   = '0;
      end
    endcase
  end

  // Double buffering: the active copy only changes on a frame boundary.
  always_comb begin
    w_pending_next = r_pending;
    w_active_next  = r_active;
    if (update) begin
      w_pending_next = digits;
    end else begin
      w_pending_next = r_pending;
    end
    if (w_frame_start) begin
      w_active_next = r_pending;
    end else begin
      w_active_next = r_active;
    end
  end

`ifdef DISPLAY_SCAN_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);
  localparam logic [BF_W-1:0] BF_ONE  = BF_W'(1);

  logic [BF_W-1:0] r_blink_cnt, w_blink_cnt_next;
  logic            r_blink_on;

  // Blink phase flips on the frame start that completes each BLINK_FRAMES run.
  always_comb begin
    w_blink_cnt_next = r_blink_cnt;
    w_blink_on_next  = r_blink_on;
    if (w_frame_start) begin
      if (r_blink_cnt == BF_LAST) begin
        w_blink_cnt_next = '0;
        w_blink_on_next  = ~r_blink_on;
      end else begin
        w_blink_cnt_next = r_blink_cnt + BF_ONE;
      end
    end else begin
      w_blink_cnt_next = r_blink_cnt;
    end
  end

  // Blink state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else begin
      r_blink_cnt <= w_blink_cnt_next;
      r_blink_on  <= w_blink_on_next;
    end
  end

  assign w_blink_mask_eff = blink_mask;
`else
  logic w_unused_blink;
  assign w_unused_blink   = ^blink_mask;
  assign w_blink_on_next  = 1'b1;
  assign w_blink_mask_eff = '0;
`endif

  // w_lz[i]: digits N_DIGITS-1 down to i of the next active buffer are all zero.
  always_comb begin
    w_lz = '0;
    w_lz[N_DIGITS-1] = (w_active_next[(N_DIGITS-1)*DIG_W +: DIG_W] == ZERO);
    for (int i = N_DIGITS - 2; i >= 0; i--) begin
      w_lz[i] = w_lz[i+1] && (w_active_next[i*DIG_W +: DIG_W] == ZERO);
    end
  end

  // Select, blanking and enable for the slot the next cycle will show.
  always_comb begin
    w_sel       = BLANK;
    w_blank_sel = 1'b0;
    w_onehot    = '0;
    w_code_next = BLANK;
    w_en_next   = EN_OFF;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w_idx_next == IDX_W'(i)) begin
        w_sel       = w_active_next[i*DIG_W +: DIG_W];
        w_blank_sel = (lzb && (i > 0) && w_lz[i]) || (w_blink_mask_eff[i] && !w_blink_on_next);
        w_onehot[N_DIGITS-1-i] = 1'b1;
      end else begin
        w_onehot[N_DIGITS-1-i] = 1'b0;
      end
    end
    if (w_state_next == ST_SHOW) begin
      w_en_next   = w_onehot ^ EN_OFF;
      w_code_next = w_blank_sel ? BLANK : w_sel;
    end else begin
      w_en_next   = EN_OFF;
      w_code_next = BLANK;
    end
  end

  // Scan state, buffers and the select/code output register pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RESET;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_pending    <= {N_DIGITS{BLANK}};
      r_active     <= {N_DIGITS{BLANK}};
      r_code       <= BLANK;
      r_enable     <= EN_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_idx        <= w_idx_next;
      r_pending    <= w_pending_next;
      r_active     <= w_active_next;
      r_code       <= w_code_next;
      r_enable     <= w_en_next;
      r_frame_tick <= w_frame_start;
    end
  end

  BCD_7segmentos #(
    .W (DIG_W)
  ) u_bcd (
    .i_bcd (r_code),
    .o_seg (segmentos)
  );

  assign enable     = r_enable;
  assign frame_tick = r_frame_tick;

endmodule

// File: doc/display_scan.md
# display_scan

Parametrised multiplexed driver for a bank of common-anode or common-cathode 7-segment digits. It replaces the fixed three-digit, one-digit-per-clock scanner with the following:
- a configurable digit count and a prescaled scan rate;
- an inter-digit guard (blanking) interval against ghosting;
- tear-free double-buffered digit loading;
- leading-zero blanking and optional per-digit blinking.

It sits between the counter/BCD logic and the board pins, and reuses the existing `BCD_7segmentos` decoder.

## Interface
- `N_DIGITS`, 3: number of digits scanned (≥2).
- `DIG_W`, 5: width of one digit code.
- `PRESCALE`, 50000: clk cycles per digit slot (guard included); must be > `GUARD`.
- `GUARD`, 16: cycles at the start of each slot with all enables inactive; 0 disables the guard.
- `BLINK_FRAMES`, 64: full frames per blink half-period.
- `EN_ACTIVE_LOW`, 0: 1 inverts `enable` polarity.
- Ports:
  - `clk`  in  1  system clock.
  - `rst_n`  in  1  asynchronous, active-low reset.
  - `digits`  in  `N_DIGITS*DIG_W`  digit codes; slice i is digit i; digit 0 is the units digit.
  - `update`  in  1  one-cycle strobe that captures `digits` into the pending buffer.
  - `lzb`  in  1  leading-zero blanking enable (level).
  - `blink_mask`  in  `N_DIGITS`  bit i set makes digit i blink.
  - `enable`  out  `N_DIGITS`  one-hot digit select; digit i drives `enable[N_DIGITS-1-i]`.
  - `segmentos`  out  7  decoded segments of the currently selected digit.
  - `frame_tick`  out  1  one-cycle pulse at the start of every frame.

## Operation
- **Buffers.**
  - `update` high copies `digits` into the pending buffer on that edge.
  - Pending is copied to the active buffer at the next frame start (slot 0 entering GUARD).
  - `update` on the same edge as a frame start: the new value goes to pending only and is shown from the following frame.
- **State machine.** States are GUARD and SHOW.
  - GUARD lasts `GUARD` cycles; SHOW lasts `PRESCALE-GUARD` cycles.
  - At the end of SHOW: slot index increments and the FSM returns to GUARD.
  - Index wraps `N_DIGITS-1` → 0.
  - With `GUARD`=0 the FSM never enters GUARD.
- **Outputs by state.**
  - In GUARD: `enable` is all inactive and the decoder input is `BLANK_CODE`.
  - In SHOW: exactly one enable bit is active (slot index) and the decoder input is the effective code of that digit.
- **Effective code for digit i.**
  - Replaced by `BLANK_CODE` if `lzb`=1, i>0, and digits `N_DIGITS-1`..i of the active buffer are all zero.
  - Replaced by `BLANK_CODE` if blink is compiled in, `blink_mask[i]`=1 and the blink phase is "off".
  - Otherwise the active code is passed unchanged.
- **Digit 0 and the decoder.** Digit 0 is never zero-blanked. `segmentos` is the `BCD_7segmentos` output of the registered code.
- **Reset values.**
  - `enable` inactive (all 0, or all 1 if `EN_ACTIVE_LOW`).
  - Registered code is `BLANK_CODE`, so `segmentos` is all segments off.
  - `frame_tick`=0; FSM in GUARD; index 0; counters 0.
  - Pending and active buffers hold `BLANK_CODE` in every digit.
  - Blink phase is "on".
- **Reset mid-scan.** Outputs go to reset values immediately (asynchronously). Scan restarts at slot 0, GUARD, and the first frame shows blanks until `update` and a frame start occur.

## Timing
- `enable` and the decoder-input code are registered and update on the same edge; `segmentos` is combinational from that register. There is no skew between select and data.
- `frame_tick` is high for the first cycle of slot 0 (GUARD, or SHOW when `GUARD`=0); frame period is `N_DIGITS*PRESCALE` cycles.
- Latency from `update` to display: pending capture at the next edge; visible at most one frame plus `GUARD`+1 cycles later.
- Blink phase toggles on the frame_tick of every `BLINK_FRAMES`-th frame.
- `lzb`/`blink_mask` are sampled each cycle; a change is visible from the next cycle.

## Configuration
- Macro `DISPLAY_SCAN_BLINK_EN`.
- Defined: blink frame counter and phase register are present and masking is applied as above.
- Undefined: counter and phase are removed; `blink_mask` is ignored and no digit ever blinks.

## Structure
- Shared package `display_pkg` holds:
  - `BLANK_CODE` (5'd17; `BCD_7segmentos` must decode it to all segments off);
  - the FSM state encoding (GUARD, SHOW);
  - the `DIG_W` default.
- One sub-module: the existing `BCD_7segmentos`, instantiated once.
- Prescaler, FSM, buffers and blanking logic live in `display_scan`.

## Test plan
Parameters for all scenarios: `N_DIGITS`=3, `PRESCALE`=8, `GUARD`=2, `BLINK_FRAMES`=2.
1. Reset, then `digits`={c=3,d=2,u=1} with `update` pulse:
   - before the next frame start, output is all blank;
   - after it, each slot shows 2 cycles of enable=000, then 6 cycles of 100/u=1, then 010/d=2, then 001/c=3;
   - `frame_tick` pulses every 24 cycles.
2. `lzb`=1, digits={0,0,7}: slots 2 and 1 decode blank, slot 0 shows 7. Digits={0,0,0} shows a single 0 in slot 0.
3. `update` with new value mid-frame: the current frame continues with old codes; the new codes appear exactly from the next `frame_tick`.
4. With `DISPLAY_SCAN_BLINK_EN` defined and `blink_mask`=010: digit 1 is blank for 2 frames and visible for 2 frames, alternating; digits 0 and 2 are unaffected. With the macro undefined, digit 1 is always visible.
5. Assert `rst_n`=0 during SHOW of slot 1: `enable`=000 and `segmentos`=off in the same cycle; after release, scan restarts at slot 0 GUARD.
6. `GUARD`=0, `EN_ACTIVE_LOW`=1: `enable` is never 111 outside reset; it cycles 011/101/110 every 8 cycles.
